// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controller.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int              WORDS             = 8;
    localparam int              IDX_W             = 3;
    localparam int              WORD_BYTES        = 2;
    localparam logic [15:0]     BLOCK_OFFSET_MASK = 16'hFFF0;

endpackage

// File: rtl/fill_counter.sv
// Enable/clear word counter with a terminal flag at the last word of a block.
module fill_counter
    import cache_pkg::*;
#(
    parameter int W = IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    assign term = &cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: stalls the pipeline, streams 8 word reads, writes data then tag.
// Optional CACHE_FILL_STATS_EN adds fill_count / fill_cycles statistics outputs.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  fill_word_sel,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_base_addr
`ifdef CACHE_FILL_STATS_EN
    ,
    output logic [15:0]       fill_count,
    output logic [15:0]       fill_cycles
`endif
);

    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(WORDS * WORD_BYTES - 1);

    state_t             state, state_nxt;
    logic               detect, issue_adv;
    logic [IDX_W-1:0]   issue_cnt, issue_nxt, rx_cnt;
    logic               issue_term, rx_term;
    logic [ADDR_W-1:0]  miss_base;

    assign detect    = (state == IDLE) && miss_detected;
    assign issue_adv = (state == FILL) && memory_read && !issue_term;
    assign issue_nxt = issue_cnt + 1'b1;
    assign miss_base = miss_address & BASE_MASK;

    // issue_cnt indexes the request currently on the bus; rx_cnt the next word to land
    fill_counter #(.W(IDX_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (detect),
        .en    (issue_adv),
        .cnt   (issue_cnt),
        .term  (issue_term)
    );

    fill_counter #(.W(IDX_W)) u_rx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (detect),
        .en    (write_data_array),
        .cnt   (rx_cnt),
        .term  (rx_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss_detected) state_nxt = FILL;
            FILL:    if (memory_data_valid && rx_term) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fsm_busy         = (state == FILL) || miss_detected;
        write_data_array = (state == FILL) && memory_data_valid;
        write_tag_array  = write_data_array && rx_term;
        fill_word_sel    = rx_cnt;
    end

    // Request bus is registered; address holds its last value once issue finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memory_read    <= 1'b0;
            memory_address <= '0;
            fill_base_addr <= '0;
        end else if (detect) begin
            memory_read    <= 1'b1;
            memory_address <= miss_base;
            fill_base_addr <= miss_base;
        end else if (issue_adv) begin
            memory_read    <= 1'b1;
            memory_address <= fill_base_addr + ADDR_W'(issue_nxt) * ADDR_W'(WORD_BYTES);
        end else begin
            memory_read    <= 1'b0;
        end
    end

`ifdef CACHE_FILL_STATS_EN
    logic [15:0] cyc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt     <= '0;
            fill_count  <= '0;
            fill_cycles <= '0;
        end else begin
            if (detect)
                cyc_cnt <= '0;
            else if (state == FILL && cyc_cnt != 16'hFFFF)
                cyc_cnt <= cyc_cnt + 1'b1;
            // Completion cycle is itself a FILL cycle, hence the +1
            if (write_tag_array) begin
                if (fill_count != 16'hFFFF) fill_count <= fill_count + 1'b1;
                fill_cycles <= (cyc_cnt == 16'hFFFF) ? 16'hFFFF : cyc_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: vector table for a basic fill plus corner-case sequences.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_sel;
    logic        write_tag_array;
    logic [15:0] fill_base_addr;
`ifdef CACHE_FILL_STATS_EN
    logic [15:0] fill_count;
    logic [15:0] fill_cycles;
`endif

    int n_vec = 0;
    int n_bad = 0;

    cache_fill_fsm #(.ADDR_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_sel     (fill_word_sel),
        .write_tag_array   (write_tag_array),
        .fill_base_addr    (fill_base_addr)
`ifdef CACHE_FILL_STATS_EN
        ,
        .fill_count        (fill_count),
        .fill_cycles       (fill_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        miss;
        logic [15:0] addr;
        logic        vld;
        logic        busy;
        logic        rd;
        logic [15:0] maddr;
        logic        wda;
        logic [2:0]  sel;
        logic        wta;
        logic [15:0] base;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [15:0] a, input logic v);
        @(negedge clk);
        miss_detected     = m;
        miss_address      = a;
        memory_data_valid = v;
        #1;
    endtask

    task automatic set_row(input int i, input logic m, input logic [15:0] a, input logic v,
                           input logic b, input logic r, input logic [15:0] ma, input logic w,
                           input logic [2:0] s, input logic t, input logic [15:0] bs);
        tbl[i] = '{m, a, v, b, r, ma, w, s, t, bs};
    endtask

    // Latency-0 fill: valid arrives in the same cycle as each read
    task automatic fill_lat0(input string nm, input logic [15:0] base);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 16'h0, 1'b1);
            chk({nm, ".rd"},   k, 16'(memory_read), 16'h1);
            chk({nm, ".addr"}, k, memory_address, base + 16'(2 * (k - 1)));
            chk({nm, ".sel"},  k, 16'(fill_word_sel), 16'(k - 1));
            chk({nm, ".wta"},  k, 16'(write_tag_array), 16'(k == 8));
        end
    endtask

    initial begin
        int n;
        int rds;
        logic v;

        rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0; memory_data_valid = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst.busy", 0, 16'(fsm_busy), 16'h0);
        chk("rst.rd",   0, 16'(memory_read), 16'h0);
        chk("rst.addr", 0, memory_address, 16'h0);
        chk("rst.wda",  0, 16'(write_data_array), 16'h0);
        chk("rst.sel",  0, 16'(fill_word_sel), 16'h0);
        chk("rst.wta",  0, 16'(write_tag_array), 16'h0);
        chk("rst.base", 0, fill_base_addr, 16'h0);
        @(negedge clk); rst_n = 1'b1;

        // Single miss at 0x1234, memory latency 4
        //          miss addr     vld busy rd maddr    wda sel wta base
        set_row( 0, 1, 16'h1234, 0,  1,  0, 16'h0000, 0, 0, 0, 16'h0000);
        set_row( 1, 0, 16'h0000, 0,  1,  1, 16'h1230, 0, 0, 0, 16'h1230);
        set_row( 2, 0, 16'h0000, 0,  1,  1, 16'h1232, 0, 0, 0, 16'h1230);
        set_row( 3, 0, 16'h0000, 0,  1,  1, 16'h1234, 0, 0, 0, 16'h1230);
        set_row( 4, 0, 16'h0000, 0,  1,  1, 16'h1236, 0, 0, 0, 16'h1230);
        set_row( 5, 0, 16'h0000, 1,  1,  1, 16'h1238, 1, 0, 0, 16'h1230);
        set_row( 6, 0, 16'h0000, 1,  1,  1, 16'h123A, 1, 1, 0, 16'h1230);
        set_row( 7, 0, 16'h0000, 1,  1,  1, 16'h123C, 1, 2, 0, 16'h1230);
        set_row( 8, 0, 16'h0000, 1,  1,  1, 16'h123E, 1, 3, 0, 16'h1230);
        set_row( 9, 0, 16'h0000, 1,  1,  0, 16'h123E, 1, 4, 0, 16'h1230);
        set_row(10, 0, 16'h0000, 1,  1,  0, 16'h123E, 1, 5, 0, 16'h1230);
        set_row(11, 0, 16'h0000, 1,  1,  0, 16'h123E, 1, 6, 0, 16'h1230);
        set_row(12, 0, 16'h0000, 1,  1,  0, 16'h123E, 1, 7, 1, 16'h1230);
        set_row(13, 0, 16'h0000, 0,  0,  0, 16'h123E, 0, 0, 0, 16'h1230);
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].miss, tbl[i].addr, tbl[i].vld);
            chk("tbl.busy", i, 16'(fsm_busy), 16'(tbl[i].busy));
            chk("tbl.rd",   i, 16'(memory_read), 16'(tbl[i].rd));
            chk("tbl.addr", i, memory_address, tbl[i].maddr);
            chk("tbl.wda",  i, 16'(write_data_array), 16'(tbl[i].wda));
            chk("tbl.sel",  i, 16'(fill_word_sel), 16'(tbl[i].sel));
            chk("tbl.wta",  i, 16'(write_tag_array), 16'(tbl[i].wta));
            chk("tbl.base", i, fill_base_addr, tbl[i].base);
        end

        // Gapped valids: 1,0,0,1,0,0,...
        drive(1'b1, 16'h2000, 1'b0);
        chk("gap.busy0", 0, 16'(fsm_busy), 16'h1);
        n = 0;
        for (int k = 1; k <= 22; k++) begin
            v = ((k - 1) % 3 == 0);
            drive(1'b0, 16'h0, v);
            chk("gap.busy", k, 16'(fsm_busy), 16'h1);
            chk("gap.wda",  k, 16'(write_data_array), 16'(v));
            chk("gap.wta",  k, 16'(write_tag_array), 16'(v && n == 7));
            if (v) begin
                chk("gap.sel", k, 16'(fill_word_sel), 16'(n));
                n++;
            end
        end
        drive(1'b0, 16'h0, 1'b0);
        chk("gap.busy_end", 0, 16'(fsm_busy), 16'h0);
        chk("gap.base",     0, fill_base_addr, 16'h2000);

        // Back-to-back misses, second one at the top of the address space
        drive(1'b1, 16'h0010, 1'b0);
        fill_lat0("b2b_a", 16'h0010);
        drive(1'b1, 16'hFFF8, 1'b0);
        chk("b2b.busy_detect", 0, 16'(fsm_busy), 16'h1);
        chk("b2b.wda_detect",  0, 16'(write_data_array), 16'h0);
        fill_lat0("b2b_b", 16'hFFF0);
        chk("b2b.base", 0, fill_base_addr, 16'hFFF0);
        drive(1'b0, 16'h0, 1'b0);
        chk("b2b.rd_end",   0, 16'(memory_read), 16'h0);
        chk("b2b.addr_end", 0, memory_address, 16'hFFFE);
        chk("b2b.busy_end", 0, 16'(fsm_busy), 16'h0);

        // Reset mid-fill after 3 valids
        drive(1'b1, 16'h3000, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 16'h0, 1'b1);
            chk("rmid.sel", k, 16'(fill_word_sel), 16'(k - 1));
        end
        @(negedge clk);
        rst_n = 1'b0; memory_data_valid = 1'b1;
        #1;
        chk("rmid.busy", 0, 16'(fsm_busy), 16'h0);
        chk("rmid.rd",   0, 16'(memory_read), 16'h0);
        chk("rmid.addr", 0, memory_address, 16'h0);
        chk("rmid.wda",  0, 16'(write_data_array), 16'h0);
        chk("rmid.sel",  0, 16'(fill_word_sel), 16'h0);
        chk("rmid.wta",  0, 16'(write_tag_array), 16'h0);
        chk("rmid.base", 0, fill_base_addr, 16'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16'h0, 1'b1);
            chk("rmid.late_wda",  k, 16'(write_data_array), 16'h0);
            chk("rmid.late_busy", k, 16'(fsm_busy), 16'h0);
        end
        drive(1'b1, 16'h0100, 1'b0);
        fill_lat0("rmid_new", 16'h0100);
        chk("rmid.new_base", 0, fill_base_addr, 16'h0100);

        // Valid in IDLE ignored; miss toggling during FILL ignored
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 16'h0, 1'b1);
            chk("idle.wda",  k, 16'(write_data_array), 16'h0);
            chk("idle.busy", k, 16'(fsm_busy), 16'h0);
        end
        drive(1'b1, 16'h4444, 1'b0);
        rds = 0;
        for (int k = 1; k <= 12; k++) begin
            drive(logic'(k % 2), 16'h8888, 1'b0);
            chk("tog.base", k, fill_base_addr, 16'h4440);
            chk("tog.busy", k, 16'(fsm_busy), 16'h1);
            if (memory_read) rds++;
        end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 16'h0, 1'b1);
            chk("tog.sel", k, 16'(fill_word_sel), 16'(k - 1));
            chk("tog.wta", k, 16'(write_tag_array), 16'(k == 8));
            if (memory_read) rds++;
        end
        chk("tog.reads", 0, 16'(rds), 16'd8);
        drive(1'b0, 16'h0, 1'b0);
        chk("tog.busy_end", 0, 16'(fsm_busy), 16'h0);
        chk("tog.base_end", 0, fill_base_addr, 16'h4440);

`ifdef CACHE_FILL_STATS_EN
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("stat.count_rst", 0, fill_count, 16'h0);
        for (int f = 0; f < 3; f++) begin
            drive(1'b1, 16'h5000 + 16'(f * 16), 1'b0);
            for (int k = 1; k <= 12; k++) drive(1'b0, 16'h0, logic'(k >= 5));
            drive(1'b0, 16'h0, 1'b0);
            chk("stat.count", f, fill_count, 16'(f + 1));
            chk("stat.cycles", f, fill_cycles, 16'd12);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller for one cache (I or D). It is the stall source for the pipeline, the counterpart to the load-use stall logic.
- On a cache miss it asserts the pipeline stall and issues 8 word reads to the pipelined multi-cycle main memory.
- It writes each returned word into the data array, then writes the tag and releases the stall.
- Sits between the cache tag-compare logic and the memory module.

Parameters:
- ADDR_W, 16, byte address width
- WORDS, 8, 16-bit words per block (block = 16 bytes)
- IDX_W, 3, log2(WORDS)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_detected  in  1  tag mismatch/invalid on current access
- miss_address  in  ADDR_W  byte address of missing access
- memory_data_valid  in  1  memory returns one word this cycle (in issue order)
- fsm_busy  out  1  stall request to PC/IF_ID/pipeline
- memory_read  out  1  read request to memory this cycle
- memory_address  out  ADDR_W  address of current read request
- write_data_array  out  1  write the returned word into the data array
- fill_word_sel  out  IDX_W  word offset for write_data_array
- write_tag_array  out  1  write tag + valid for the block
- fill_base_addr  out  ADDR_W  latched block base address

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs and counters 0.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the stall covers the detect cycle).
  - On miss_detected: latch fill_base_addr = miss_address & ~0xF; clear issue_cnt and rx_cnt; next state FILL.
  - memory_data_valid in IDLE is ignored.
- FILL: fsm_busy = 1.
- Issue phase, registered outputs:
  - First request is in the cycle after detect.
  - memory_read = 1 while issue_cnt < WORDS; memory_address = base + 2*issue_cnt; issue_cnt increments each cycle.
  - 8 requests go out in 8 consecutive cycles, then memory_read = 0 and memory_address holds its last value.
- Receive phase, overlaps issue:
  - Each memory_data_valid pulses write_data_array in the same cycle, with fill_word_sel = rx_cnt; rx_cnt then increments.
  - Valid gaps are allowed; the FSM waits with no timeout.
- Completion:
  - The cycle with the 8th valid (rx_cnt = 7) also pulses write_tag_array.
  - Next state IDLE; fsm_busy drops the following cycle unless miss_detected is high again.
- Address arithmetic: modulo 2^ADDR_W; a block never straddles the wrap point because base is 16-byte aligned.
- miss_detected and miss_address are ignored during FILL; no re-latch.
- A valid that would be the 9th in FILL cannot occur, because the FSM is already in IDLE, where valid is ignored.
- Back-to-back misses: miss_detected in the cycle after completion starts a new fill with no dead cycle beyond that one.
- Reset mid-operation: immediate return to IDLE, outputs 0; memory responses still in flight arrive in IDLE and are discarded.

Optional Feature:
- Macro: CACHE_FILL_STATS_EN.
- Defined:
  - Adds output fill_count (16 bits), reset to 0.
  - Increments once per write_tag_array pulse and saturates at 0xFFFF.
  - Adds output fill_cycles (16 bits) holding the FILL-state cycle count of the last completed fill.
- Undefined: neither port exists; no counters are synthesized.

Decomposition:
- Shared package cache_pkg:
  - state enum (IDLE, FILL)
  - WORDS, IDX_W, BLOCK_OFFSET_MASK (16'hFFF0)
  - WORD_BYTES = 2
- One natural sub-module: fill_counter, a 3-bit enable/clear counter with a terminal flag. It is instantiated twice, for issue and receive.

Test Plan:
- Single miss at 0x1234, memory latency 4:
  - fsm_busy high in the detect cycle; reads to 0x1230, 0x1232, …, 0x123E in 8 consecutive cycles.
  - write_data_array at sel 0..7 in the 8 cycles starting 4 after the first read.
  - write_tag_array with sel 7; fsm_busy low the next cycle; fill_base_addr = 0x1230.
- Gapped valids (valid pattern 1,0,0,1,…): sel increments only on valid; tag written only on the 8th valid; busy stays high throughout.
- Back-to-back misses 0x0010 then 0xFFF8: second fill has base 0xFFF0 and addresses 0xFFF0..0xFFFE, with no wrap past 0xFFFE.
- rst_n pulsed low after 3 valids: all outputs 0 immediately; late valids ignored; a new miss at 0x0100 fills sel 0..7 cleanly.
- memory_data_valid pulsed in IDLE and miss_detected toggled during FILL: no array writes in IDLE, base unchanged, exactly 8 reads issued.
- With CACHE_FILL_STATS_EN defined, 3 fills: fill_count = 3; fill_cycles equals the measured FILL duration (12 for latency 4, no gaps).
